// File: rtl/inval_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : inval_responder                                                 |
// | Purpose  : Queues invalidate addresses from a producer and hands them to   |
// |            the cache one at a time over the main bus. The cache polls      |
// |            with a request carrying the invalidate tag. If the queue is     |
// |            empty, the request is not answered, and the cache reads that    |
// |            silence as end-of-stream. A response that is not acknowledged   |
// |            within TIMEOUT cycles is withdrawn and kept in the queue.       |
// | Ports    : clk, reset                    - clock, sync active-high reset   |
// |            inval_valid/inval_addr/       - producer push handshake         |
// |            inval_ready                                                     |
// |            main_bus_reqcyc/reqtag        - cache request strobe and tag    |
// |            main_bus_respcyc/resp/resptag - response toward the cache       |
// |            main_bus_respack              - cache accepts the response      |
// |            pending                       - number of queued entries        |
// |            timeout_err                   - one-cycle pulse on ack timeout  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module inval_responder #(
  parameter int         BUS_DATA_WIDTH = 64,
  parameter int         BUS_TAG_WIDTH  = 13,
  parameter logic [3:0] INVAL_CODE     = 4'h3,
  parameter int         DEPTH          = 8,
  parameter int         TIMEOUT        = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      inval_valid,
  input  logic [BUS_DATA_WIDTH-1:0] inval_addr,
  output logic                      inval_ready,
  input  logic                      main_bus_reqcyc,
  input  logic [BUS_TAG_WIDTH-1:0]  main_bus_reqtag,
  output logic                      main_bus_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] main_bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  main_bus_resptag,
  input  logic                      main_bus_respack,
  output logic [$clog2(DEPTH):0]    pending,
  output logic                      timeout_err
);

  localparam int AW = $clog2(DEPTH);
  // The counter never holds more than TIMEOUT-1, so $clog2(TIMEOUT) bits are enough.
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  localparam logic [AW:0]              DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [TW-1:0]            TCNT_LAST = TW'(TIMEOUT - 1);
  localparam logic [BUS_TAG_WIDTH-1:0] INVAL_TAG = BUS_TAG_WIDTH'({INVAL_CODE, 8'h00});

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t                    state_q, state_d;
  logic [AW-1:0]             wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]             rd_ptr_q, rd_ptr_d;
  logic [AW:0]               count_q, count_d;
  logic [TW-1:0]             tcnt_q, tcnt_d;
  logic                      terr_q, terr_d;
  logic [BUS_DATA_WIDTH-1:0] mem_q [DEPTH];

  logic push;
  logic pop;
  logic req_hit;

  // inval_ready comes from the registered count. A pop in the same cycle
  // therefore does not free room for a push into a full queue.
  assign inval_ready = (count_q < DEPTH_CNT);
  assign push        = inval_valid && inval_ready;
  assign req_hit     = main_bus_reqcyc && (main_bus_reqtag == INVAL_TAG) && (count_q != '0);

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    terr_d  = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_hit) begin
          state_d = PRESENT;
          tcnt_d  = '0;
        end
      end
      PRESENT: begin
        // An ack wins over a timeout that expires in the same cycle.
        if (main_bus_respack) begin
          pop     = 1'b1;
          state_d = IDLE;
        end else if (tcnt_q == TCNT_LAST) begin
          state_d = IDLE;
          terr_d  = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      tcnt_q   <= '0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      tcnt_q   <= tcnt_d;
      terr_q   <= terr_d;
    end
  end

  // The storage array needs no reset. Pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= inval_addr;
    end
  end

  // The head entry cannot change while PRESENT. It is popped only on exit,
  // and a push never targets the head slot of a non-empty queue.
  assign main_bus_respcyc = (state_q == PRESENT);
  assign main_bus_resp    = (state_q == PRESENT) ? mem_q[rd_ptr_q] : '0;
  assign main_bus_resptag = (state_q == PRESENT) ? INVAL_TAG : '0;
  assign pending          = count_q;
  assign timeout_err      = terr_q;

endmodule
`default_nettype wire

// File: tb/tb_inval_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_inval_responder                                              |
// | Purpose  : Self-checking bench for inval_responder using a vector table    |
// |            plus hand-written multi-cycle sequences.                        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_inval_responder;

  localparam logic [12:0] TAG = 13'h300;
  localparam logic [12:0] BAD = 13'h100;

  logic        clk = 1'b0;
  logic        reset;
  logic        inval_valid;
  logic [63:0] inval_addr;
  logic        inval_ready;
  logic        main_bus_reqcyc;
  logic [12:0] main_bus_reqtag;
  logic        main_bus_respcyc;
  logic [63:0] main_bus_resp;
  logic [12:0] main_bus_resptag;
  logic        main_bus_respack;
  logic [3:0]  pending;
  logic        timeout_err;

  int checks   = 0;
  int failures = 0;

  inval_responder dut (
    .clk              (clk),
    .reset            (reset),
    .inval_valid      (inval_valid),
    .inval_addr       (inval_addr),
    .inval_ready      (inval_ready),
    .main_bus_reqcyc  (main_bus_reqcyc),
    .main_bus_reqtag  (main_bus_reqtag),
    .main_bus_respcyc (main_bus_respcyc),
    .main_bus_resp    (main_bus_resp),
    .main_bus_resptag (main_bus_resptag),
    .main_bus_respack (main_bus_respack),
    .pending          (pending),
    .timeout_err      (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [63:0] addr;
    logic        rq;
    logic [12:0] tag;
    logic        ack;
    logic        e_cyc;
    logic [63:0] e_resp;
    logic [12:0] e_tag;
    logic [3:0]  e_pend;
    logic        e_rdy;
    logic        e_terr;
  } vec_t;

  vec_t vecs [21];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic e_cyc, input logic [63:0] e_resp,
                         input logic [12:0] e_tag, input logic [3:0] e_pend,
                         input logic e_rdy, input logic e_terr);
    chk({name, ".respcyc"}, 64'(main_bus_respcyc), 64'(e_cyc));
    chk({name, ".resp"}, main_bus_resp, e_resp);
    chk({name, ".resptag"}, 64'(main_bus_resptag), 64'(e_tag));
    chk({name, ".pending"}, 64'(pending), 64'(e_pend));
    chk({name, ".ready"}, 64'(inval_ready), 64'(e_rdy));
    chk({name, ".terr"}, 64'(timeout_err), 64'(e_terr));
  endtask

  task automatic clear_inputs();
    inval_valid      = 1'b0;
    inval_addr       = '0;
    main_bus_reqcyc  = 1'b0;
    main_bus_reqtag  = '0;
    main_bus_respack = 1'b0;
  endtask

  initial begin
    // Single push, present, ack.
    vecs[0]  = '{1'b1, 64'h1000, 1'b0, 13'h0, 1'b0, 1'b0, 64'h0,    13'h0, 4'd1, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 64'h0,    1'b1, TAG,   1'b0, 1'b1, 64'h1000, TAG,   4'd1, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 64'h0,    1'b0, 13'h0, 1'b1, 1'b0, 64'h0,    13'h0, 4'd0, 1'b1, 1'b0};
    // Three pushes, three in-order rounds, then end-of-stream.
    vecs[3]  = '{1'b1, 64'hA0,   1'b0, 13'h0, 1'b0, 1'b0, 64'h0,    13'h0, 4'd1, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 64'hB0,   1'b0, 13'h0, 1'b0, 1'b0, 64'h0,    13'h0, 4'd2, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 64'hC0,   1'b0, 13'h0, 1'b0, 1'b0, 64'h0,    13'h0, 4'd3, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 64'h0,    1'b1, TAG,   1'b0, 1'b1, 64'hA0,   TAG,   4'd3, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 64'h0,    1'b0, 13'h0, 1'b1, 1'b0, 64'h0,    13'h0, 4'd2, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 64'h0,    1'b1, TAG,   1'b0, 1'b1, 64'hB0,   TAG,   4'd2, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 64'h0,    1'b0, 13'h0, 1'b1, 1'b0, 64'h0,    13'h0, 4'd1, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 64'h0,    1'b1, TAG,   1'b0, 1'b1, 64'hC0,   TAG,   4'd1, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 64'h0,    1'b0, 13'h0, 1'b1, 1'b0, 64'h0,    13'h0, 4'd0, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 64'h0,    1'b1, TAG,   1'b0, 1'b0, 64'h0,    13'h0, 4'd0, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 64'h0,    1'b0, 13'h0, 1'b0, 1'b0, 64'h0,    13'h0, 4'd0, 1'b1, 1'b0};
    // Wrong tag ignored, request during PRESENT ignored, push+pop same cycle.
    vecs[14] = '{1'b1, 64'h55,   1'b0, 13'h0, 1'b0, 1'b0, 64'h0,    13'h0, 4'd1, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 64'h0,    1'b1, BAD,   1'b0, 1'b0, 64'h0,    13'h0, 4'd1, 1'b1, 1'b0};
    vecs[16] = '{1'b0, 64'h0,    1'b1, TAG,   1'b0, 1'b1, 64'h55,   TAG,   4'd1, 1'b1, 1'b0};
    vecs[17] = '{1'b0, 64'h0,    1'b1, TAG,   1'b0, 1'b1, 64'h55,   TAG,   4'd1, 1'b1, 1'b0};
    vecs[18] = '{1'b1, 64'h66,   1'b0, 13'h0, 1'b1, 1'b0, 64'h0,    13'h0, 4'd1, 1'b1, 1'b0};
    vecs[19] = '{1'b0, 64'h0,    1'b1, TAG,   1'b0, 1'b1, 64'h66,   TAG,   4'd1, 1'b1, 1'b0};
    vecs[20] = '{1'b0, 64'h0,    1'b0, 13'h0, 1'b1, 1'b0, 64'h0,    13'h0, 4'd0, 1'b1, 1'b0};

    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    chk_all("reset", 1'b0, 64'h0, 13'h0, 4'd0, 1'b1, 1'b0);
    reset = 1'b0;
    tick();
    chk_all("post_reset", 1'b0, 64'h0, 13'h0, 4'd0, 1'b1, 1'b0);

    for (int i = 0; i < 21; i++) begin
      inval_valid      = vecs[i].v;
      inval_addr       = vecs[i].addr;
      main_bus_reqcyc  = vecs[i].rq;
      main_bus_reqtag  = vecs[i].tag;
      main_bus_respack = vecs[i].ack;
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].e_cyc, vecs[i].e_resp, vecs[i].e_tag,
              vecs[i].e_pend, vecs[i].e_rdy, vecs[i].e_terr);
    end
    clear_inputs();

    // Fill to capacity. The ninth push must be refused.
    for (int i = 0; i < 9; i++) begin
      inval_valid = 1'b1;
      inval_addr  = 64'h200 + 64'(i);
      tick();
      chk($sformatf("fill%0d.pending", i), 64'(pending), (i < 8) ? 64'(i + 1) : 64'd8);
      chk($sformatf("fill%0d.ready", i), 64'(inval_ready), (i < 7) ? 64'd1 : 64'd0);
    end
    clear_inputs();
    // Drain. On the first pop, also offer a push into the full queue; it must be refused.
    for (int i = 0; i < 8; i++) begin
      main_bus_reqcyc = 1'b1;
      main_bus_reqtag = TAG;
      tick();
      main_bus_reqcyc = 1'b0;
      chk($sformatf("drain%0d.respcyc", i), 64'(main_bus_respcyc), 64'd1);
      chk($sformatf("drain%0d.resp", i), main_bus_resp, 64'h200 + 64'(i));
      main_bus_respack = 1'b1;
      if (i == 0) begin
        inval_valid = 1'b1;
        inval_addr  = 64'hDEAD;
      end
      tick();
      clear_inputs();
      chk($sformatf("drain%0d.pending", i), 64'(pending), 64'(7 - i));
      chk($sformatf("drain%0d.cyc_off", i), 64'(main_bus_respcyc), 64'd0);
    end
    main_bus_reqcyc = 1'b1;
    main_bus_reqtag = TAG;
    tick();
    clear_inputs();
    chk("drain_empty.respcyc", 64'(main_bus_respcyc), 64'd0);

    // Timeout: the response is held for 15 cycles, then withdrawn with one error pulse.
    inval_valid = 1'b1;
    inval_addr  = 64'h777;
    tick();
    clear_inputs();
    main_bus_reqcyc = 1'b1;
    main_bus_reqtag = TAG;
    tick();
    clear_inputs();
    chk_all("to_enter", 1'b1, 64'h777, TAG, 4'd1, 1'b1, 1'b0);
    for (int i = 1; i < 15; i++) begin
      tick();
      chk($sformatf("to_hold%0d.respcyc", i), 64'(main_bus_respcyc), 64'd1);
      chk($sformatf("to_hold%0d.terr", i), 64'(timeout_err), 64'd0);
    end
    tick();
    chk_all("to_fire", 1'b0, 64'h0, 13'h0, 4'd1, 1'b1, 1'b1);
    tick();
    chk("to_pulse_end.terr", 64'(timeout_err), 64'd0);

    // Re-request gets the same address. An ack in the final cycle wins over the timeout.
    main_bus_reqcyc = 1'b1;
    main_bus_reqtag = TAG;
    tick();
    clear_inputs();
    chk_all("retry", 1'b1, 64'h777, TAG, 4'd1, 1'b1, 1'b0);
    for (int i = 1; i < 15; i++) tick();
    main_bus_respack = 1'b1;
    tick();
    clear_inputs();
    chk_all("ack_wins", 1'b0, 64'h0, 13'h0, 4'd0, 1'b1, 1'b0);
    tick();
    chk("ack_wins_after.terr", 64'(timeout_err), 64'd0);

    // Reset while PRESENT with three entries queued.
    for (int i = 0; i < 3; i++) begin
      inval_valid = 1'b1;
      inval_addr  = 64'h900 + 64'(i);
      tick();
    end
    clear_inputs();
    main_bus_reqcyc = 1'b1;
    main_bus_reqtag = TAG;
    tick();
    clear_inputs();
    chk_all("pre_reset", 1'b1, 64'h900, TAG, 4'd3, 1'b1, 1'b0);
    reset = 1'b1;
    tick();
    chk_all("mid_reset", 1'b0, 64'h0, 13'h0, 4'd0, 1'b1, 1'b0);
    reset = 1'b0;
    main_bus_reqcyc = 1'b1;
    main_bus_reqtag = TAG;
    tick();
    clear_inputs();
    chk_all("after_reset_req", 1'b0, 64'h0, 13'h0, 4'd0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
